// File: rtl/blit_pkg.sv
// Shared definitions for the blit sequencer.
// Holds the command opcodes, the sequencer state encoding and the default
// coordinate width used by the interface and the sequencer top.
package blit_pkg;

    localparam int BLIT_COORD_W = 16;

    localparam logic [1:0] BLIT_OP_NOP  = 2'd0;
    localparam logic [1:0] BLIT_OP_RECT = 2'd1;
    localparam logic [1:0] BLIT_OP_LINE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECT = 2'd1,
        ST_LINE = 2'd2
    } blit_state_e;

endpackage

// File: rtl/blit_sequencer_if.sv
// Command/pixel bus between the blitter command register file, the blit
// sequencer and the address generator.
//   master : command issuer (drives cmd_*, observes cmd_ready, p2_*, busy, done)
//   slave  : the sequencer (accepts cmd_*, drives cmd_ready, p2_*, busy, done)
interface blit_sequencer_if
    import blit_pkg::*;
#(
    parameter int COORD_W = BLIT_COORD_W
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x1, cmd_y1, cmd_x2, cmd_y2;
    logic [COORD_W-1:0] cmd_width, cmd_height;
    logic [COORD_W-1:0] cmd_src_x, cmd_src_y;
    logic               cmd_textmode;
    logic               cmd_reverse;

    logic [COORD_W-1:0] p2_rect_dest_x, p2_rect_dest_y;
    logic [COORD_W-1:0] p2_rect_src_x, p2_rect_src_y;
    logic [COORD_W-1:0] p2_line_x, p2_line_y;
    logic               p2_run_rect, p2_run_line;
    logic               p2_textmode;
    logic               busy;
    logic               done;

    modport master (
        output cmd_valid, cmd_op, cmd_x1, cmd_y1, cmd_x2, cmd_y2,
               cmd_width, cmd_height, cmd_src_x, cmd_src_y,
               cmd_textmode, cmd_reverse,
        input  cmd_ready, p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x,
               p2_rect_src_y, p2_line_x, p2_line_y, p2_run_rect,
               p2_run_line, p2_textmode, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x1, cmd_y1, cmd_x2, cmd_y2,
               cmd_width, cmd_height, cmd_src_x, cmd_src_y,
               cmd_textmode, cmd_reverse,
        output cmd_ready, p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x,
               p2_rect_src_y, p2_line_x, p2_line_y, p2_run_rect,
               p2_run_line, p2_textmode, busy, done
    );

endinterface

// File: rtl/blit_bresenham_step.sv
// One Bresenham step for the LINE walker (purely combinational).
// Ports:
//   err_i, dx_i, dy_i : signed error accumulator, +|dx|, -|dy|
//   sx_neg_i/sy_neg_i : 1 = step in the negative direction on that axis
//   x_i, y_i          : current pixel
//   err_o, x_o, y_o   : values for the next pixel
module blit_bresenham_step #(
    parameter int COORD_W = 16,
    parameter int ERR_W   = 18
) (
    input  logic signed [ERR_W-1:0]   err_i,
    input  logic signed [ERR_W-1:0]   dx_i,
    input  logic signed [ERR_W-1:0]   dy_i,
    input  logic                      sx_neg_i,
    input  logic                      sy_neg_i,
    input  logic        [COORD_W-1:0] x_i,
    input  logic        [COORD_W-1:0] y_i,
    output logic signed [ERR_W-1:0]   err_o,
    output logic        [COORD_W-1:0] x_o,
    output logic        [COORD_W-1:0] y_o
);
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    // 2*err needs one extra bit; dx/dy are sign-extended to match.
    logic signed [ERR_W:0] e2, dx_w, dy_w;
    logic                  step_x, step_y;

    always_comb begin
        e2     = {err_i, 1'b0};
        dx_w   = {dx_i[ERR_W-1], dx_i};
        dy_w   = {dy_i[ERR_W-1], dy_i};
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
        err_o  = err_i;
        x_o    = x_i;
        y_o    = y_i;
        if (step_x) begin
            err_o = err_o + dy_i;
            x_o   = sx_neg_i ? x_i - ONE : x_i + ONE;
        end
        if (step_y) begin
            err_o = err_o + dx_i;
            y_o   = sy_neg_i ? y_i - ONE : y_i + ONE;
        end
    end

endmodule

// File: rtl/blit_sequencer.sv
// Blit command sequencer: turns RECT / LINE commands into one pixel per
// unstalled cycle for the address generator's p2 inputs.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   stall  : downstream stall, freezes all state and outputs
//   bus    : blit_sequencer_if.slave (command handshake, p2 pixel outputs,
//            busy, done)
// Optional feature macro: BLIT_SEQ_REVERSE_EN -- when defined, cmd_reverse=1
// on a RECT scans from the far corner back toward the origin.
module blit_sequencer
    import blit_pkg::*;
#(
    parameter int COORD_W = BLIT_COORD_W,
    parameter int ERR_W   = COORD_W + 2
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            stall,
    blit_sequencer_if.slave bus
);
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    blit_state_e             state_q;
    logic [COORD_W-1:0]      dest_x_q, dest_y_q, src_x_q, src_y_q;
    logic [COORD_W-1:0]      dest_x0_q, src_x0_q;
    logic [COORD_W-1:0]      col_q, row_q, col_last_q, row_last_q;
    logic [COORD_W-1:0]      line_x_q, line_y_q, x2_q, y2_q;
    logic signed [ERR_W-1:0] err_q, dx_q, dy_q;
    logic                    sx_neg_q, sy_neg_q;
    logic                    run_rect_q, run_line_q, textmode_q, done_q;

    logic [COORD_W-1:0]      dest_x_d, dest_y_d, src_x_d, src_y_d, col_d, row_d;
    logic [COORD_W-1:0]      line_x_d, line_y_d;
    logic signed [ERR_W-1:0] err_d;
    logic                    rect_last_col, rect_last_pix, line_last;
    logic [COORD_W-1:0]      step;
    logic [COORD_W-1:0]      start_x, start_y, start_sx, start_sy;
    logic [COORD_W-1:0]      adx, ady;
    logic                    cmd_ready, accept;

`ifdef BLIT_SEQ_REVERSE_EN
    logic rev_q;
    // Reverse scan starts at the far corner and adds all-ones (i.e. -1).
    always_comb begin
        step = rev_q ? '1 : ONE;
        if (bus.cmd_reverse) begin
            start_x  = bus.cmd_x1    + bus.cmd_width  - ONE;
            start_y  = bus.cmd_y1    + bus.cmd_height - ONE;
            start_sx = bus.cmd_src_x + bus.cmd_width  - ONE;
            start_sy = bus.cmd_src_y + bus.cmd_height - ONE;
        end else begin
            start_x  = bus.cmd_x1;
            start_y  = bus.cmd_y1;
            start_sx = bus.cmd_src_x;
            start_sy = bus.cmd_src_y;
        end
    end
`else
    logic unused_reverse;
    assign unused_reverse = bus.cmd_reverse;
    assign step     = ONE;
    assign start_x  = bus.cmd_x1;
    assign start_y  = bus.cmd_y1;
    assign start_sx = bus.cmd_src_x;
    assign start_sy = bus.cmd_src_y;
`endif

    // Commands are only taken while unstalled so that a stall freezes IDLE too.
    assign cmd_ready = (state_q == ST_IDLE) && !stall;
    assign accept    = bus.cmd_valid && cmd_ready;
    assign adx = (bus.cmd_x2 >= bus.cmd_x1) ? bus.cmd_x2 - bus.cmd_x1 : bus.cmd_x1 - bus.cmd_x2;
    assign ady = (bus.cmd_y2 >= bus.cmd_y1) ? bus.cmd_y2 - bus.cmd_y1 : bus.cmd_y1 - bus.cmd_y2;

    // RECT walk: column/row counters decide the wrap and the end, so the
    // coordinates themselves may wrap around 2^COORD_W freely.
    always_comb begin
        rect_last_col = (col_q == col_last_q);
        rect_last_pix = rect_last_col && (row_q == row_last_q);
        dest_x_d = dest_x_q + step;
        src_x_d  = src_x_q + step;
        dest_y_d = dest_y_q;
        src_y_d  = src_y_q;
        col_d    = col_q + ONE;
        row_d    = row_q;
        if (rect_last_col) begin
            dest_x_d = dest_x0_q;
            src_x_d  = src_x0_q;
            dest_y_d = dest_y_q + step;
            src_y_d  = src_y_q + step;
            col_d    = '0;
            row_d    = row_q + ONE;
        end
    end

    assign line_last = (line_x_q == x2_q) && (line_y_q == y2_q);

    blit_bresenham_step #(.COORD_W(COORD_W), .ERR_W(ERR_W)) u_step (
        .err_i   (err_q),
        .dx_i    (dx_q),
        .dy_i    (dy_q),
        .sx_neg_i(sx_neg_q),
        .sy_neg_i(sy_neg_q),
        .x_i     (line_x_q),
        .y_i     (line_y_q),
        .err_o   (err_d),
        .x_o     (line_x_d),
        .y_o     (line_y_d)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            dest_x_q   <= '0;  dest_y_q   <= '0;
            src_x_q    <= '0;  src_y_q    <= '0;
            dest_x0_q  <= '0;  src_x0_q   <= '0;
            col_q      <= '0;  row_q      <= '0;
            col_last_q <= '0;  row_last_q <= '0;
            line_x_q   <= '0;  line_y_q   <= '0;
            x2_q       <= '0;  y2_q       <= '0;
            err_q      <= '0;  dx_q       <= '0;  dy_q <= '0;
            sx_neg_q   <= 1'b0; sy_neg_q  <= 1'b0;
            run_rect_q <= 1'b0; run_line_q <= 1'b0;
            textmode_q <= 1'b0; done_q    <= 1'b0;
`ifdef BLIT_SEQ_REVERSE_EN
            rev_q      <= 1'b0;
`endif
        end else if (!stall) begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        textmode_q <= bus.cmd_textmode;
                        case (bus.cmd_op)
                            BLIT_OP_RECT: begin
                                if (bus.cmd_width == '0 || bus.cmd_height == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q    <= ST_RECT;
                                    run_rect_q <= 1'b1;
                                    dest_x_q   <= start_x;  dest_x0_q <= start_x;
                                    src_x_q    <= start_sx; src_x0_q  <= start_sx;
                                    dest_y_q   <= start_y;
                                    src_y_q    <= start_sy;
                                    col_q      <= '0;
                                    row_q      <= '0;
                                    col_last_q <= bus.cmd_width - ONE;
                                    row_last_q <= bus.cmd_height - ONE;
`ifdef BLIT_SEQ_REVERSE_EN
                                    rev_q      <= bus.cmd_reverse;
`endif
                                end
                            end
                            BLIT_OP_LINE: begin
                                state_q    <= ST_LINE;
                                run_line_q <= 1'b1;
                                line_x_q   <= bus.cmd_x1;
                                line_y_q   <= bus.cmd_y1;
                                x2_q       <= bus.cmd_x2;
                                y2_q       <= bus.cmd_y2;
                                sx_neg_q   <= (bus.cmd_x2 < bus.cmd_x1);
                                sy_neg_q   <= (bus.cmd_y2 < bus.cmd_y1);
                                dx_q       <= ERR_W'(adx);
                                dy_q       <= -$signed(ERR_W'(ady));
                                err_q      <= $signed(ERR_W'(adx)) - $signed(ERR_W'(ady));
                            end
                            // NOP and the reserved opcode complete immediately.
                            default: done_q <= 1'b1;
                        endcase
                    end
                end
                ST_RECT: begin
                    if (rect_last_pix) begin
                        state_q    <= ST_IDLE;
                        run_rect_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        dest_x_q <= dest_x_d; dest_y_q <= dest_y_d;
                        src_x_q  <= src_x_d;  src_y_q  <= src_y_d;
                        col_q    <= col_d;    row_q    <= row_d;
                    end
                end
                ST_LINE: begin
                    if (line_last) begin
                        state_q    <= ST_IDLE;
                        run_line_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        line_x_q <= line_x_d;
                        line_y_q <= line_y_d;
                        err_q    <= err_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready      = cmd_ready;
    assign bus.p2_rect_dest_x = dest_x_q;
    assign bus.p2_rect_dest_y = dest_y_q;
    assign bus.p2_rect_src_x  = src_x_q;
    assign bus.p2_rect_src_y  = src_y_q;
    assign bus.p2_line_x      = line_x_q;
    assign bus.p2_line_y      = line_y_q;
    assign bus.p2_run_rect    = run_rect_q;
    assign bus.p2_run_line    = run_line_q;
    assign bus.p2_textmode    = textmode_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = done_q;

endmodule

// File: tb/tb_blit_sequencer.sv
`timescale 1ns/1ps
module tb_blit_sequencer;
    import blit_pkg::*;

    localparam int CW = 16;
    typedef logic [2+4*CW-1:0] pix_t;   // {run_rect, run_line, a, b, c, d}

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic stall  = 1'b0;
    always #5 clock = ~clock;

    blit_sequencer_if #(.COORD_W(CW)) bus ();
    blit_sequencer #(.COORD_W(CW), .ERR_W(CW + 2)) dut (
        .clock (clock),
        .resetn(resetn),
        .stall (stall),
        .bus   (bus)
    );

    pix_t exp_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, pix_cnt = 0, done_cnt = 0, last_pix_cyc = 0, done_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic pix_t rp(input int dx, input int dy, input int sx, input int sy);
        return {2'b10, CW'(dx), CW'(dy), CW'(sx), CW'(sy)};
    endfunction

    function automatic pix_t lp(input int x, input int y);
        return {2'b01, CW'(x), CW'(y), {(2*CW){1'b0}}};
    endfunction

    // Scoreboard: every pixel presented with stall low is popped and compared.
    always @(negedge clock) begin
        pix_t got, want;
        if (resetn && (bus.p2_run_rect || bus.p2_run_line) && !stall) begin
            if (bus.p2_run_rect)
                got = {bus.p2_run_rect, bus.p2_run_line, bus.p2_rect_dest_x, bus.p2_rect_dest_y,
                       bus.p2_rect_src_x, bus.p2_rect_src_y};
            else
                got = {bus.p2_run_rect, bus.p2_run_line, bus.p2_line_x, bus.p2_line_y, {(2*CW){1'b0}}};
            pix_cnt++;
            last_pix_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h, expected no pixel", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL sb_pixel: got %h, expected %h", got, want);
                end
            end
        end
        if (resetn && bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clr();
        pix_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input int x1, input int y1, input int x2, input int y2,
                            input int w, input int h, input int sx, input int sy,
                            input logic tm, input logic rev);
        bus.cmd_op     = op;
        bus.cmd_x1     = CW'(x1);  bus.cmd_y1     = CW'(y1);
        bus.cmd_x2     = CW'(x2);  bus.cmd_y2     = CW'(y2);
        bus.cmd_width  = CW'(w);   bus.cmd_height = CW'(h);
        bus.cmd_src_x  = CW'(sx);  bus.cmd_src_y  = CW'(sy);
        bus.cmd_textmode = tm;
        bus.cmd_reverse  = rev;
        bus.cmd_valid    = 1'b1;
        for (int k = 0; k < 20 && bus.cmd_ready !== 1'b1; k++) @(negedge clock);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_timeout: got %b, expected 1", bus.cmd_ready);
        end
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clock); #1;
            if (bus.done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", bus.cmd_ready); end
        checks++;
        if ({bus.p2_run_rect, bus.p2_run_line, bus.busy, bus.done, bus.p2_textmode} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 00000",
                     {bus.p2_run_rect, bus.p2_run_line, bus.busy, bus.done, bus.p2_textmode});
        end
        checks++;
        if ({bus.p2_rect_dest_x, bus.p2_rect_dest_y, bus.p2_rect_src_x, bus.p2_rect_src_y,
             bus.p2_line_x, bus.p2_line_y} !== '0) begin
            errors++;
            $display("FAIL reset_coords: got %h, expected 0",
                     {bus.p2_rect_dest_x, bus.p2_rect_dest_y, bus.p2_rect_src_x, bus.p2_rect_src_y,
                      bus.p2_line_x, bus.p2_line_y});
        end
        #2 resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_rect();
        bit ok;
        clr();
        exp_q.push_back(rp(10, 20, 0, 0)); exp_q.push_back(rp(11, 20, 1, 0));
        exp_q.push_back(rp(12, 20, 2, 0)); exp_q.push_back(rp(10, 21, 0, 1));
        exp_q.push_back(rp(11, 21, 1, 1)); exp_q.push_back(rp(12, 21, 2, 1));
        send_cmd(BLIT_OP_RECT, 10, 20, 0, 0, 3, 2, 0, 0, 1'b1, 1'b0);
        checks++;
        if (bus.p2_textmode !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rect_start: textmode/busy got %b%b, expected 11", bus.p2_textmode, bus.busy);
        end
        wait_done(40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rect_done: done not seen, expected within 40 cycles"); end
        checks++;
        if (pix_cnt != 6) begin errors++; $display("FAIL rect_count: got %0d, expected 6", pix_cnt); end
        checks++;
        if (done_cyc != last_pix_cyc + 1) begin
            errors++; $display("FAIL rect_done_lat: got cycle %0d, expected %0d", done_cyc, last_pix_cyc + 1);
        end
        checks++;
        if (bus.p2_run_rect !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL rect_end: run_rect=%b left=%0d, expected 0 and 0", bus.p2_run_rect, exp_q.size());
        end
        @(posedge clock); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rect_pulse: done/busy/ready got %b%b%b, expected 001", bus.done, bus.busy, bus.cmd_ready);
        end
    endtask

    task automatic test_line();
        bit ok;
        clr();
        exp_q.push_back(lp(0, 0)); exp_q.push_back(lp(1, 0)); exp_q.push_back(lp(2, 1));
        exp_q.push_back(lp(3, 1)); exp_q.push_back(lp(4, 2)); exp_q.push_back(lp(5, 2));
        send_cmd(BLIT_OP_LINE, 0, 0, 5, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        wait_done(40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL line_done: done not seen, expected within 40 cycles"); end
        checks++;
        if (pix_cnt != 6 || exp_q.size() != 0) begin
            errors++; $display("FAIL line_count: got %0d left %0d, expected 6 left 0", pix_cnt, exp_q.size());
        end
        checks++;
        if (bus.p2_run_line !== 1'b0 || done_cyc != last_pix_cyc + 1) begin
            errors++; $display("FAIL line_end: run_line=%b done_cyc=%0d, expected 0 and %0d",
                               bus.p2_run_line, done_cyc, last_pix_cyc + 1);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_single_and_zero();
        bit ok;
        clr();
        exp_q.push_back(lp(3, 3));
        send_cmd(BLIT_OP_LINE, 3, 3, 3, 3, 0, 0, 0, 0, 1'b0, 1'b0);
        wait_done(10, ok);
        checks++;
        if (!ok || pix_cnt != 1) begin
            errors++; $display("FAIL single_point: done=%b pixels=%0d, expected 1 and 1", ok, pix_cnt);
        end
        @(posedge clock); #1;
        // zero-width RECT, NOP and reserved opcode: no pixels, done right after accept
        for (int t = 0; t < 3; t++) begin
            clr();
            send_cmd((t == 0) ? BLIT_OP_RECT : ((t == 1) ? BLIT_OP_NOP : 2'd3), 1, 1, 0, 0, (t == 0) ? 0 : 4, 3, 0, 0, 1'b0, 1'b0);
            checks++;
            if (bus.done !== 1'b1 || bus.p2_run_rect !== 1'b0 || bus.p2_run_line !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL zero_cmd%0d: done/rect/line/ready got %b%b%b%b, expected 1001",
                                   t, bus.done, bus.p2_run_rect, bus.p2_run_line, bus.cmd_ready);
            end
            @(posedge clock); #1;
            checks++;
            if (bus.done !== 1'b0 || pix_cnt != 0) begin
                errors++; $display("FAIL zero_pulse%0d: done=%b pixels=%0d, expected 0 and 0", t, bus.done, pix_cnt);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        clr();
        for (int i = 0; i < 4; i++) exp_q.push_back(rp(i, 0, i, 0));
        send_cmd(BLIT_OP_RECT, 0, 0, 0, 0, 4, 1, 0, 0, 1'b0, 1'b0);
        @(posedge clock); #1;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (bus.p2_rect_dest_x !== CW'(1) || bus.p2_run_rect !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: x=%0d run=%b, expected 1 and 1", k, bus.p2_rect_dest_x, bus.p2_run_rect);
            end
            @(posedge clock); #1;
        end
        stall = 1'b0;
        checks++;
        if (bus.p2_rect_dest_x !== CW'(1)) begin
            errors++; $display("FAIL stall_release: x=%0d, expected 1", bus.p2_rect_dest_x);
        end
        wait_done(20, ok);
        checks++;
        if (!ok || pix_cnt != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_total: done=%b pixels=%0d left=%0d, expected 1, 4, 0", ok, pix_cnt, exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr();
        for (int i = 5; i >= 0; i--) exp_q.push_back(lp(i, i));
        send_cmd(BLIT_OP_LINE, 5, 5, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (pix_cnt != 3 || exp_q.size() != 3) begin
            errors++; $display("FAIL rstmid_progress: pixels=%0d left=%0d, expected 3 and 3", pix_cnt, exp_q.size());
        end
        checks++;
        if ({bus.p2_run_line, bus.busy, bus.done, bus.p2_textmode} !== 4'b0 || bus.p2_line_x !== '0 ||
            bus.p2_line_y !== '0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_async: run/busy/done/tm=%b xy=%0d,%0d ready=%b, expected 0000 0,0 1",
                               {bus.p2_run_line, bus.busy, bus.done, bus.p2_textmode},
                               bus.p2_line_x, bus.p2_line_y, bus.cmd_ready);
        end
        exp_q.delete();
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL rstmid_done: got %0d done pulses, expected 0", done_cnt); end
        @(posedge clock); #1;
        clr();
        exp_q.push_back(rp(7, 8, 1, 1)); exp_q.push_back(rp(8, 8, 2, 1));
        send_cmd(BLIT_OP_RECT, 7, 8, 0, 0, 2, 1, 1, 1, 1'b0, 1'b0);
        wait_done(20, ok);
        checks++;
        if (!ok || pix_cnt != 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL rstmid_after: done=%b pixels=%0d left=%0d, expected 1, 2, 0", ok, pix_cnt, exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d1;
        clr();
        exp_q.push_back(rp(0, 5, 0, 0)); exp_q.push_back(rp(1, 5, 1, 0));
        exp_q.push_back(lp(0, 0)); exp_q.push_back(lp(0, 1));
        exp_q.push_back(lp(1, 2)); exp_q.push_back(lp(1, 3));
        send_cmd(BLIT_OP_RECT, 0, 5, 0, 0, 2, 1, 0, 0, 1'b0, 1'b0);
        wait_done(20, ok);
        d1 = done_cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_first: done not seen, expected within 20 cycles"); end
        send_cmd(BLIT_OP_LINE, 0, 0, 1, 3, 0, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (bus.p2_run_line !== 1'b1 || cyc != d1 + 1) begin
            errors++; $display("FAIL b2b_gap: run_line=%b cycle=%0d, expected 1 and %0d", bus.p2_run_line, cyc, d1 + 1);
        end
        wait_done(20, ok);
        checks++;
        if (!ok || pix_cnt != 6 || done_cnt != 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_total: done=%b pixels=%0d pulses=%0d left=%0d, expected 1, 6, 2, 0",
                               ok, pix_cnt, done_cnt, exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reverse();
        bit ok;
        clr();
`ifdef BLIT_SEQ_REVERSE_EN
        exp_q.push_back(rp(1, 1, 5, 5)); exp_q.push_back(rp(0, 1, 4, 5));
        exp_q.push_back(rp(1, 0, 5, 4)); exp_q.push_back(rp(0, 0, 4, 4));
`else
        exp_q.push_back(rp(0, 0, 4, 4)); exp_q.push_back(rp(1, 0, 5, 4));
        exp_q.push_back(rp(0, 1, 4, 5)); exp_q.push_back(rp(1, 1, 5, 5));
`endif
        send_cmd(BLIT_OP_RECT, 0, 0, 0, 0, 2, 2, 4, 4, 1'b0, 1'b1);
        wait_done(20, ok);
        checks++;
        if (!ok || pix_cnt != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL reverse: done=%b pixels=%0d left=%0d, expected 1, 4, 0", ok, pix_cnt, exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0;
        bus.cmd_x1 = '0; bus.cmd_y1 = '0; bus.cmd_x2 = '0; bus.cmd_y2 = '0;
        bus.cmd_width = '0; bus.cmd_height = '0; bus.cmd_src_x = '0; bus.cmd_src_y = '0;
        bus.cmd_textmode = 1'b0; bus.cmd_reverse = 1'b0;
        test_reset();
        test_rect();
        test_line();
        test_single_and_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_reverse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blit_sequencer.md
Name: blit_sequencer

Overview:
- Command-level sequencer that drives the blitter address generator's p2 inputs, one pixel per non-stalled cycle.
- Accepts RECT commands (fill or copy, dest and src stepped in lockstep) and LINE commands (Bresenham, endpoints inclusive) over a valid/ready handshake.
- Emits per-pixel coordinates plus run strobes; clipping and address arithmetic stay downstream.
- Sits between the blitter command register file and the address generator; shares the pipeline stall.

Parameters:
COORD_W, 16, coordinate and extent width.
ERR_W, 18, signed Bresenham error accumulator width (COORD_W+2).

Ports:
clock  in  1  system clock, all state rising-edge.
resetn  in  1  asynchronous active-low reset.
stall  in  1  downstream stall; holds every output and all internal state when high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready.
cmd_op  in  2  0 NOP, 1 RECT, 2 LINE, 3 reserved (treated as NOP).
cmd_x1, cmd_y1  in  COORD_W each  RECT dest origin / LINE start.
cmd_x2, cmd_y2  in  COORD_W each  LINE end (ignored for RECT).
cmd_width, cmd_height  in  COORD_W each  RECT extent in pixels.
cmd_src_x, cmd_src_y  in  COORD_W each  RECT source origin.
cmd_textmode  in  1  latched, forwarded as p2_textmode.
cmd_reverse  in  1  reverse RECT scan (see Optional Feature).
p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x, p2_rect_src_y  out  COORD_W each  current RECT pixel.
p2_line_x, p2_line_y  out  COORD_W each  current LINE pixel.
p2_run_rect, p2_run_line  out  1 each  pixel-valid strobes, mutually exclusive.
p2_textmode  out  1  latched textmode.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse when a command completes, including NOP and zero-extent commands.

Behaviour:
Reset values:
- All outputs 0 except cmd_ready=1.
- State IDLE.
- Asserting resetn low mid-command aborts immediately: no done pulse, run strobes low.

States: IDLE, RECT, LINE.

IDLE:
- On accept, latch all cmd fields.
- RECT with width==0 or height==0, NOP, or reserved op: stay IDLE, pulse done next cycle.
- RECT otherwise: enter RECT; first pixel presented the cycle after accept.
- LINE: enter LINE.

RECT:
- Start at (x1,y1)/(src_x,src_y).
- Each cycle with stall low, advance x; at column width-1, wrap x to the origin and increment y. Src coordinates track dest.
- After pixel (x1+width-1, y1+height-1) is presented with stall low, go to IDLE and pulse done in that same transition cycle.
- p2_run_rect=1 throughout RECT.

LINE:
- Setup: dx=|x2-x1|, dy=-|y2-y1|, sx/sy=±1, err=dx+dy (ERR_W signed).
- Per unstalled pixel:
  - e2=2*err.
  - If e2>=dy: err+=dy, x+=sx.
  - If e2<=dx: err+=dx, y+=sy.
  - Both updates apply in the same cycle when both conditions hold.
- Terminate after presenting (x2,y2) with stall low.
- A single-point line (x1==x2, y1==y2) emits exactly one pixel.
- p2_run_line=1 throughout LINE.

Stall and timing:
- stall high freezes coordinates, err, state and done; outputs are held stable.
- A new command may be accepted the cycle after done; no bubble is required beyond that.

Arithmetic:
- Coordinates wrap modulo 2^COORD_W.
- Rect end computed as x1+width-1 in COORD_W+1 bits; a comparison against the counter avoids wrap ambiguity.
- Max pixel count width*height is not limited.

Optional Feature:
BLIT_SEQ_REVERSE_EN:
- Defined: cmd_reverse=1 on RECT scans from (x1+width-1, y1+height-1) toward the origin, decrementing x then y, with src mirrored identically. This supports overlapping copies where dest > src.
- Undefined: cmd_reverse is ignored and the scan is always forward; decrement logic is not synthesized.

Decomposition:
- Shared package blit_pkg: opcode constants BLIT_OP_NOP/RECT/LINE, state encoding, COORD_W default.
- Sub-module blit_bresenham_step: combinational error/step update for LINE (inputs err, dx, dy, sx, sy, x, y; outputs next values), instantiated once.

Test Plan:
- RECT x1=10,y1=20,w=3,h=2,src=(0,0), stall=0 -> dest sequence (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), src (0,0)..(2,1), done 1 cycle after the last pixel, 6 run_rect cycles.
- LINE (0,0)->(5,2) -> pixels (0,0)(1,0)(2,1)(3,1)(4,2)(5,2), p2_run_line for exactly 6 cycles, then done.
- LINE (3,3)->(3,3) and RECT w=0 -> one pixel / zero pixels respectively, done pulses, cmd_ready back high.
- RECT 4x1 with stall high for 3 cycles on the 2nd pixel -> (1,0) held for 4 cycles, no skipped or duplicated pixels, total 4 distinct pixels.
- resetn low during a LINE (5,5)->(0,0) mid-way -> outputs 0 asynchronously, no done; a following RECT executes normally.
- With BLIT_SEQ_REVERSE_EN, RECT x1=0,y1=0,w=2,h=2,reverse=1 -> (1,1)(0,1)(1,0)(0,0); without the macro, the same command gives forward order.
